mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single byte-serial external memory port (uio pins plus a req/ack pair) between two requesters.
//   - Port 0: CPU core.
//   - Port 1: debug/DMA loader.
//  Arbitrates between them, latches the winner's command and sequences the ADDR_LO -> ADDR_HI -> DATA
//  byte phases over a 4-phase handshake. hs_ack is synchronised internally.
// PARAMETERS
//  ADDR_W       16  requester address width; must be 16 (two address bytes)
//  SYNC_STAGES  2   flops in the hs_ack synchroniser (>=2)
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   reset, asynchronous, active-low
//  m0_rd/m0_wr  in   1   port 0 read / write request (level, held until m0_done)
//  m0_addr      in   16  port 0 address
//  m0_wdata     in   8   port 0 write data
//  m0_rdata     out  8   port 0 read data, valid in the m0_done cycle
//  m0_done      out  1   port 0 one-cycle completion pulse
//  m1_*         --   --  identical set for port 1
//  bus_in       in   8   external bus read data (uio_in)
//  bus_out      out  8   external bus drive data (uio_out)
//  bus_oe       out  8   external bus output enable: 8'hff or 8'h00
//  hs_req       out  1   handshake request to external agent (registered)
//  hs_ack       in   1   handshake acknowledge, asynchronous to clk
//  grant        out  2   one-hot current owner; 0 when idle
// BEHAVIOUR
//  Reset values (all outputs): hs_req=0, bus_oe=0, bus_out=0, grant=0, m*_done=0, m*_rdata=0;
//   state=IDLE; RR pointer=port 0.
//  States: IDLE, LO_REQ, LO_REL, HI_REQ, HI_REL, D_REQ, D_REL.
//  IDLE: if any request is pending, choose a winner and register grant, addr, wdata and dir
//   (wr wins if rd&wr both set). Then go to LO_REQ. First hs_req rises 1 cycle after the request is seen.
//  *_REQ: hs_req=1. bus_out = addr[7:0] / addr[15:8] / wdata. bus_oe=ff in LO/HI, and in D only for writes.
//   Wait for ack_s=1 (ack_s = synchronised hs_ack), then go to *_REL.
//  *_REL: hs_req=0. bus_oe holds its value from *_REQ. Wait for ack_s=0, then go to the next phase's REQ.
//   D_REL goes to IDLE.
//  Data phase: in D_REQ, on the cycle ack_s=1, capture bus_in into the winner's rdata (reads)
//   and pulse the winner's done. Done is not delayed until D_REL.
//  The loser's done never pulses. A loser's request stays pending and is served after D_REL completes.
//  Commands are latched at grant: addr/wdata changes mid-transaction are ignored.
//   Dropping rd/wr before done does not abort the transaction.
//  Arbitration: fixed priority, port 0 wins on a tie.
//   The arbiter is evaluated only in IDLE; no preemption.
//  Back-to-back: a request held through the done cycle starts a new transaction after D_REL (not re-granted early).
//  hs_ack already high while IDLE: LO_REQ waits in REL-style until ack_s=0 before asserting hs_req
//   (no false ack).
//  Reset mid-operation: all state returns to reset values immediately. The external agent must tolerate hs_req
//   dropping.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: on a tie the port not served last wins.
//   The RR pointer updates on each done. A port with sole request always wins.
//  Undefined: fixed priority as above. The RR pointer logic is not synthesised.
// TESTING
//  Tests use an external agent model that acks after 3 cycles.
//  1 m0 read 0x1234, agent returns 0xA5 -> bus_out sequence 0x34, 0x12 with oe=ff.
//    Data phase oe=00. m0_rdata=0xA5 with one m0_done pulse. grant=01 throughout.
//  2 m1 write 0xBEEF<-0x5C -> bus_out 0xEF, 0xBE, 0x5C with oe=ff in all three phases. m1_done once.
//    m0 outputs unchanged.
//  3 m0 and m1 request in the same cycle, default build -> m0 served first, then m1. Exactly one done each, in order.
//  4 Same stimulus with ARB_ROUND_ROBIN_EN, both held for 4 transactions -> grant order 01, 10, 01, 10.
//  5 rst_n low during HI_REQ of a write -> hs_req=0, bus_oe=0, grant=0 within the reset.
//    After release, a new read completes normally.
//  6 hs_ack held high before the request -> no hs_req rise until ack low. No done until a full handshake occurs.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter for the byte-serial external memory port: grants one requester, then
// runs ADDR_LO, ADDR_HI, DATA over a 4-phase req/ack handshake. Define ARB_ROUND_ROBIN_EN for RR ties.
module mem_bus_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_rd,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [7:0]        m0_wdata,
  output logic [7:0]        m0_rdata,
  output logic              m0_done,
  input  logic              m1_rd,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [7:0]        m1_wdata,
  output logic [7:0]        m1_rdata,
  output logic              m1_done,
  input  logic [7:0]        bus_in,
  output logic [7:0]        bus_out,
  output logic [7:0]        bus_oe,
  output logic              hs_req,
  input  logic              hs_ack,
  output logic [1:0]        grant
);

  typedef enum logic [2:0] {
    IDLE,
    LO_REQ,
    LO_REL,
    HI_REQ,
    HI_REL,
    D_REQ,
    D_REL
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hs_req_q, hs_req_d;
  logic [1:0]             grant_q, grant_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [7:0]             wdata_q, wdata_d;
  logic                   wr_q, wr_d;
  logic [7:0]             rdata0_q, rdata0_d;
  logic [7:0]             rdata1_q, rdata1_d;
  logic                   done0_q, done0_d;
  logic                   done1_q, done1_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic                   rr_q, rr_d;
`endif

  logic ack_s;
  logic req0, req1;
  logic pick1;

  assign ack_s = sync_q[SYNC_STAGES-1];
  assign req0  = m0_rd | m0_wr;
  assign req1  = m1_rd | m1_wr;

  // rr_q set means port 1 is preferred on a tie.
`ifdef ARB_ROUND_ROBIN_EN
  assign pick1 = req1 & (~req0 | rr_q);
`else
  assign pick1 = req1 & ~req0;
`endif

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], hs_ack};
    state_d  = state_q;
    hs_req_d = hs_req_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    rr_d     = rr_q;
`endif

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_d  = pick1 ? 2'b10 : 2'b01;
          addr_d   = pick1 ? m1_addr : m0_addr;
          wdata_d  = pick1 ? m1_wdata : m0_wdata;
          wr_d     = pick1 ? m1_wr : m0_wr;
          // A stale ack still high from the agent holds off the first request.
          hs_req_d = ~ack_s;
          state_d  = LO_REQ;
        end
      end
      LO_REQ, HI_REQ, D_REQ: begin
        if (!hs_req_q) begin
          if (!ack_s) hs_req_d = 1'b1;
        end else if (ack_s) begin
          hs_req_d = 1'b0;
          case (state_q)
            LO_REQ:  state_d = LO_REL;
            HI_REQ:  state_d = HI_REL;
            default: begin
              state_d = D_REL;
              if (grant_q[0]) begin
                done0_d = 1'b1;
                if (!wr_q) rdata0_d = bus_in;
              end else begin
                done1_d = 1'b1;
                if (!wr_q) rdata1_d = bus_in;
              end
`ifdef ARB_ROUND_ROBIN_EN
              rr_d = grant_q[0];
`endif
            end
          endcase
        end
      end
      LO_REL: begin
        if (!ack_s) begin
          hs_req_d = 1'b1;
          state_d  = HI_REQ;
        end
      end
      HI_REL: begin
        if (!ack_s) begin
          hs_req_d = 1'b1;
          state_d  = D_REQ;
        end
      end
      D_REL: begin
        if (!ack_s) begin
          grant_d = 2'b00;
          state_d = IDLE;
        end
      end
      default: begin
        hs_req_d = 1'b0;
        grant_d  = 2'b00;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sync_q   <= '0;
      hs_req_q <= 1'b0;
      grant_q  <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= 8'h00;
      wr_q     <= 1'b0;
      rdata0_q <= 8'h00;
      rdata1_q <= 8'h00;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      hs_req_q <= hs_req_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q     <= rr_d;
`endif
    end
  end

  // Bus drive follows the phase; REL keeps the byte and enable of its REQ.
  always_comb begin
    bus_out = 8'h00;
    bus_oe  = 8'h00;
    case (state_q)
      LO_REQ, LO_REL: begin
        bus_out = addr_q[7:0];
        bus_oe  = 8'hff;
      end
      HI_REQ, HI_REL: begin
        bus_out = addr_q[15:8];
        bus_oe  = 8'hff;
      end
      D_REQ, D_REL: begin
        bus_out = wdata_q;
        bus_oe  = wr_q ? 8'hff : 8'h00;
      end
      default: begin
        bus_out = 8'h00;
        bus_oe  = 8'h00;
      end
    endcase
  end

  assign hs_req   = hs_req_q;
  assign grant    = grant_q;
  assign m0_done  = done0_q;
  assign m1_done  = done1_q;
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a 3-cycle ack agent, randomized requester rounds and a
// transaction-order reference model; directed reset and stale-ack scenarios.
module tb_mem_bus_arbiter;

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } cmd_t;

  typedef struct packed {
    logic port;
    cmd_t cmd;
  } exp_t;

  typedef struct packed {
    logic [2:0][7:0] b;
    logic [2:0][7:0] oe;
    logic [2:0][1:0] g;
  } obs_t;

  logic        clk;
  logic        rst_n;
  logic        m0_rd, m0_wr, m1_rd, m1_wr;
  logic [15:0] m0_addr, m1_addr;
  logic [7:0]  m0_wdata, m1_wdata;
  logic [7:0]  m0_rdata, m1_rdata;
  logic        m0_done, m1_done;
  logic [7:0]  bus_in, bus_out, bus_oe;
  logic        hs_req, hs_ack;
  logic [1:0]  grant;

  int   vectors;
  int   miscompares;
  int   done_cnt;
  cmd_t cmd_q0[$];
  cmd_t cmd_q1[$];
  exp_t exp_q[$];
  obs_t obs_q[$];
  logic rr_model;
  logic [7:0] exp_rdata0, exp_rdata1;

  logic agent_en, force_ack;
  int   agent_cnt, agent_phase;
  obs_t cur_obs;

  mem_bus_arbiter #(.ADDR_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_done(m0_done),
    .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_done(m1_done),
    .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .hs_req(hs_req), .hs_ack(hs_ack), .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The external memory answers every read with a fixed function of the address it was sent.
  function automatic logic [7:0] mem_f(logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic setPort(int p, logic v, cmd_t c);
    if (p == 0) begin
      m0_rd = v & c.rd; m0_wr = v & c.wr; m0_addr = c.addr; m0_wdata = c.wdata;
    end else begin
      m1_rd = v & c.rd; m1_wr = v & c.wr; m1_addr = c.addr; m1_wdata = c.wdata;
    end
  endtask

  function automatic cmd_t randCmd();
    cmd_t c;
    c.wr    = 1'($urandom_range(0, 1));
    c.rd    = c.wr ? 1'($urandom_range(0, 1)) : 1'b1;
    c.addr  = 16'($urandom);
    c.wdata = 8'($urandom);
    return c;
  endfunction

  // Predicts the service order for everything queued, assuming all requests rise together.
  task automatic applyStimulus();
    int   r0, r1, i0, i1;
    exp_t e;
    r0 = cmd_q0.size(); r1 = cmd_q1.size(); i0 = 0; i1 = 0;
    while (r0 > 0 || r1 > 0) begin
      if (r0 > 0 && r1 > 0) begin
`ifdef ARB_ROUND_ROBIN_EN
        e.port = rr_model;
`else
        e.port = 1'b0;
`endif
      end else begin
        e.port = (r0 > 0) ? 1'b0 : 1'b1;
      end
      if (e.port == 1'b0) begin e.cmd = cmd_q0[i0]; i0++; r0--; end
      else begin e.cmd = cmd_q1[i1]; i1++; r1--; end
      exp_q.push_back(e);
      rr_model = (e.port == 1'b0);
    end
    if (cmd_q0.size() > 0) setPort(0, 1'b1, cmd_q0[0]);
    if (cmd_q1.size() > 0) setPort(1, 1'b1, cmd_q1[0]);
  endtask

  task automatic waitRound(string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || grant !== 2'b00 || hs_ack !== 1'b0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_complete"}, (n >= 3000) ? 1 : 0, 0);
    checkOutput({name, "_obs_left"}, obs_q.size(), 0);
    if (n >= 3000) begin
      exp_q.delete(); obs_q.delete(); cmd_q0.delete(); cmd_q1.delete();
      setPort(0, 1'b0, '0); setPort(1, 1'b0, '0);
    end
    @(negedge clk);
  endtask

  // External agent: follows hs_req with a 3-cycle delay and records what each phase drove.
  always @(negedge clk) begin
    if (!agent_en) begin
      hs_ack    = force_ack;
      agent_cnt = 0;
    end else if (hs_req !== hs_ack) begin
      agent_cnt++;
      if (agent_cnt >= 3) begin
        if (hs_req) begin
          cur_obs.b[agent_phase]  = bus_out;
          cur_obs.oe[agent_phase] = bus_oe;
          cur_obs.g[agent_phase]  = grant;
          if (agent_phase == 2) begin
            bus_in = mem_f({cur_obs.b[1], cur_obs.b[0]});
            obs_q.push_back(cur_obs);
            agent_phase = 0;
          end else begin
            agent_phase++;
          end
        end
        hs_ack    = hs_req;
        agent_cnt = 0;
      end
    end else begin
      agent_cnt = 0;
    end
  end

  task automatic handleDone(int p);
    exp_t       e;
    obs_t       o;
    logic [1:0] onehot;
    onehot = (p == 0) ? 2'b01 : 2'b10;
    done_cnt++;
    if (exp_q.size() == 0) begin
      checkOutput("unexpected_done", 1, 0);
    end else begin
      e = exp_q.pop_front();
      checkOutput("done_port", p, 32'(e.port));
      checkOutput("grant_at_done", grant, onehot);
      if (e.port == 1'(p) && !e.cmd.wr) begin
        if (p == 0) exp_rdata0 = mem_f(e.cmd.addr); else exp_rdata1 = mem_f(e.cmd.addr);
      end
      if (obs_q.size() == 0) begin
        checkOutput("bus_phases_seen", 0, 1);
      end else begin
        o = obs_q.pop_front();
        checkOutput("addr_lo", o.b[0], e.cmd.addr[7:0]);
        checkOutput("addr_hi", o.b[1], e.cmd.addr[15:8]);
        checkOutput("oe_lo", o.oe[0], 8'hff);
        checkOutput("oe_hi", o.oe[1], 8'hff);
        checkOutput("oe_data", o.oe[2], e.cmd.wr ? 8'hff : 8'h00);
        if (e.cmd.wr) checkOutput("wdata", o.b[2], e.cmd.wdata);
        checkOutput("grant_phases", {o.g[2], o.g[1], o.g[0]}, {onehot, onehot, onehot});
      end
    end
    checkOutput("m0_rdata", m0_rdata, exp_rdata0);
    checkOutput("m1_rdata", m1_rdata, exp_rdata1);
    if (p == 0) begin
      if (cmd_q0.size() > 0) void'(cmd_q0.pop_front());
      if (cmd_q0.size() > 0) setPort(0, 1'b1, cmd_q0[0]); else setPort(0, 1'b0, '0);
    end else begin
      if (cmd_q1.size() > 0) void'(cmd_q1.pop_front());
      if (cmd_q1.size() > 0) setPort(1, 1'b1, cmd_q1[0]); else setPort(1, 1'b0, '0);
    end
  endtask

  // Monitor: every done pulse is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (m0_done && m1_done) checkOutput("both_done", 1, 0);
      if (m0_done) handleDone(0);
      if (m1_done) handleDone(1);
    end
  end

  task automatic checkIdleOutputs(string name);
    checkOutput({name, "_hs_req"}, hs_req, 0);
    checkOutput({name, "_bus_oe"}, bus_oe, 0);
    checkOutput({name, "_bus_out"}, bus_out, 0);
    checkOutput({name, "_grant"}, grant, 0);
    checkOutput({name, "_done"}, {m1_done, m0_done}, 0);
    checkOutput({name, "_rdata"}, {m1_rdata, m0_rdata}, 0);
  endtask

  initial begin
    int   n;
    int   hi;
    int   d0;
    cmd_t c;
    vectors = 0; miscompares = 0; done_cnt = 0;
    rr_model = 1'b0; exp_rdata0 = 8'h00; exp_rdata1 = 8'h00;
    agent_en = 1'b1; force_ack = 1'b0; agent_cnt = 0; agent_phase = 0; cur_obs = '0;
    hs_ack = 1'b0; bus_in = 8'h00;
    setPort(0, 1'b0, '0); setPort(1, 1'b0, '0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkIdleOutputs("in_reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkIdleOutputs("after_reset");

    c = '{wr: 1'b0, rd: 1'b1, addr: 16'h1234, wdata: 8'h00};
    cmd_q0.push_back(c);
    applyStimulus();
    waitRound("m0_read");

    c = '{wr: 1'b1, rd: 1'b0, addr: 16'hBEEF, wdata: 8'h5C};
    cmd_q1.push_back(c);
    applyStimulus();
    waitRound("m1_write");

    cmd_q0.push_back(randCmd()); cmd_q1.push_back(randCmd());
    applyStimulus();
    waitRound("tie");

    for (int k = 0; k < 2; k++) begin
      cmd_q0.push_back(randCmd()); cmd_q1.push_back(randCmd());
    end
    applyStimulus();
    waitRound("back_to_back");

    for (int r = 0; r < 25; r++) begin
      int mask;
      int reps;
      mask = $urandom_range(1, 3);
      reps = $urandom_range(1, 2);
      for (int k = 0; k < reps; k++) begin
        if (mask[0]) cmd_q0.push_back(randCmd());
        if (mask[1]) cmd_q1.push_back(randCmd());
      end
      applyStimulus();
      waitRound("random");
    end

    // Reset while the high address byte of a write is on the bus.
    c = '{wr: 1'b1, rd: 1'b0, addr: 16'h4321, wdata: 8'h99};
    cmd_q0.push_back(c);
    applyStimulus();
    n = 0;
    while (!(agent_phase == 1 && hs_req === 1'b1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reach_hi_req", (n >= 500) ? 1 : 0, 0);
    rst_n = 1'b0;
    #1;
    checkIdleOutputs("mid_reset");
    exp_q.delete(); obs_q.delete(); cmd_q0.delete(); cmd_q1.delete();
    setPort(0, 1'b0, '0); setPort(1, 1'b0, '0);
    rr_model = 1'b0; exp_rdata0 = 8'h00; exp_rdata1 = 8'h00;
    agent_phase = 0;
    repeat (6) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    cmd_q0.push_back('{wr: 1'b0, rd: 1'b1, addr: 16'h0F0F, wdata: 8'h00});
    applyStimulus();
    waitRound("post_reset_read");

    // Ack already high before the request: no handshake may start until it falls.
    agent_en = 1'b0; force_ack = 1'b1;
    repeat (5) @(negedge clk);
    d0 = done_cnt;
    cmd_q0.push_back('{wr: 1'b0, rd: 1'b1, addr: 16'hA0B1, wdata: 8'h00});
    applyStimulus();
    hi = 0;
    repeat (12) begin
      @(negedge clk);
      if (hs_req !== 1'b0) hi++;
    end
    checkOutput("stale_ack_no_req", hi, 0);
    checkOutput("stale_ack_no_done", done_cnt - d0, 0);
    force_ack = 1'b0;
    repeat (3) @(negedge clk);
    agent_phase = 0;
    agent_en = 1'b1;
    waitRound("stale_ack");
    checkOutput("stale_ack_one_done", done_cnt - d0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
